// File: rtl/sigma_delta_adc_post.sv
`default_nettype none
// ============================================================================
//  Module   : sigma_delta_adc_post
//  Purpose  : Post-processing for the CIC decimator output. Converts the
//             offset-binary word to signed, removes DC with a leaky
//             integrator, rounds/saturates to OUT_W bits and queues the
//             samples in a first-word-fall-through FIFO (valid/ready).
//  Revision : 1.0  initial release
// ============================================================================
module sigma_delta_adc_post #(
   parameter int IN_W       = 18,
   parameter int OUT_W      = 16,
   parameter int DC_SHIFT   = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IN_W-1:0]               in_data,
   input  logic                          in_valid,
   input  logic                          dc_bypass,
   input  logic                          clr_status,
   output logic [OUT_W-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          sat_flag,
   output logic [7:0]                    drop_cnt
);

   localparam int c_sh    = IN_W - OUT_W;
   localparam int c_acc_w = IN_W + DC_SHIFT;
   localparam int c_y_w   = IN_W + 1;
   localparam int c_aw    = $clog2(FIFO_DEPTH);

   // Clamp limits in the widened rounding domain and in the output domain
   localparam logic signed [c_y_w:0] c_max_w = (c_y_w+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [c_y_w:0] c_min_w = (c_y_w+1)'(-(1 << (OUT_W-1)));
   localparam logic [OUT_W-1:0]      c_max_o = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]      c_min_o = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [c_aw:0]         c_depth = (c_aw+1)'(FIFO_DEPTH);

   // Pipeline registers
   logic                      v1_q, v1_d;
   logic signed [IN_W-1:0]    x_q, x_d;
   logic                      v2_q, v2_d;
   logic signed [c_y_w-1:0]   y_q, y_d;
   logic signed [c_acc_w-1:0] acc_q, acc_d;
   logic                      v3_q, v3_d;
   logic [OUT_W-1:0]          r_q, r_d;

   // FIFO and status registers
   logic [OUT_W-1:0]          mem_q [FIFO_DEPTH];
   logic [c_aw:0]             wr_ptr_q, wr_ptr_d;
   logic [c_aw:0]             rd_ptr_q, rd_ptr_d;
   logic                      overflow_q, overflow_d;
   logic                      sat_q, sat_d;
   logic [7:0]                drop_cnt_q, drop_cnt_d;

   // Combinational helpers
   logic signed [IN_W-1:0]    dc_w;
   logic signed [c_y_w:0]     r_full_w;
   logic                      sat_evt_w;
   logic [c_aw:0]             level_w;
   logic                      full_w;
   logic                      pop_w;
   logic                      push_ok_w;
   logic                      drop_w;

   // DC estimate is the accumulator scaled down by 2^DC_SHIFT (floor)
   assign dc_w = IN_W'(acc_q >>> DC_SHIFT);

   // Round half up by adding half an output LSB before the arithmetic shift
   if (c_sh > 0) begin : g_round_shift
      localparam int c_half = 1 << (c_sh - 1);
      logic signed [c_y_w:0] sum_w;
      assign sum_w    = (c_y_w+1)'(y_q) + (c_y_w+1)'(c_half);
      assign r_full_w = sum_w >>> c_sh;
   end else begin : g_round_none
      assign r_full_w = (c_y_w+1)'(y_q);
   end

   assign sat_evt_w  = v2_q && ((r_full_w > c_max_w) || (r_full_w < c_min_w));

   assign level_w    = wr_ptr_q - rd_ptr_q;
   assign full_w     = (level_w == c_depth);
   assign out_valid  = (level_w != '0);
   assign pop_w      = out_valid && out_ready;
   // A full FIFO still takes a sample when the head leaves in the same cycle
   assign push_ok_w  = v3_q && (!full_w || pop_w);
   assign drop_w     = v3_q && !push_ok_w;

   assign out_data   = out_valid ? mem_q[rd_ptr_q[c_aw-1:0]] : '0;
   assign fifo_level = level_w;
   assign overflow   = overflow_q;
   assign sat_flag   = sat_q;
   assign drop_cnt   = drop_cnt_q;

   // Next-state for the three pipeline stages and the DC tracker
   always_comb begin
      v1_d  = in_valid;
      x_d   = x_q;
      if (in_valid) begin
         x_d = {~in_data[IN_W-1], in_data[IN_W-2:0]};
      end

      v2_d  = v1_q;
      acc_d = acc_q;
      if (dc_bypass) begin
         y_d = c_y_w'(x_q);
      end else begin
         y_d = c_y_w'(x_q) - c_y_w'(dc_w);
         if (v1_q) begin
            acc_d = acc_q + c_acc_w'(y_d);
         end
      end
      if (!v1_q) begin
         y_d = y_q;
      end

      v3_d = v2_q;
      r_d  = r_q;
      if (v2_q) begin
         if (r_full_w > c_max_w) begin
            r_d = c_max_o;
         end else if (r_full_w < c_min_w) begin
            r_d = c_min_o;
         end else begin
            r_d = OUT_W'(r_full_w);
         end
      end
   end

   // Next-state for FIFO pointers and sticky status; a set event beats a clear
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok_w) begin
         wr_ptr_d = wr_ptr_q + (c_aw+1)'(1);
      end
      if (pop_w) begin
         rd_ptr_d = rd_ptr_q + (c_aw+1)'(1);
      end

      overflow_d = clr_status ? 1'b0 : overflow_q;
      sat_d      = clr_status ? 1'b0 : sat_q;
      drop_cnt_d = clr_status ? 8'd0 : drop_cnt_q;
      if (drop_w) begin
         overflow_d = 1'b1;
         if (drop_cnt_d != 8'hFF) begin
            drop_cnt_d = drop_cnt_d + 8'd1;
         end
      end
      if (sat_evt_w) begin
         sat_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         v1_q       <= 1'b0;
         x_q        <= '0;
         v2_q       <= 1'b0;
         y_q        <= '0;
         acc_q      <= '0;
         v3_q       <= 1'b0;
         r_q        <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         sat_q      <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         v1_q       <= v1_d;
         x_q        <= x_d;
         v2_q       <= v2_d;
         y_q        <= y_d;
         acc_q      <= acc_d;
         v3_q       <= v3_d;
         r_q        <= r_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         sat_q      <= sat_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // FIFO storage; contents need no reset because the pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_ok_w) begin
         mem_q[wr_ptr_q[c_aw-1:0]] <= r_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_adc_post.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sigma_delta_adc_post
//  Purpose  : Self-checking bench for sigma_delta_adc_post with a
//             transaction-level reference model (arithmetic + queues).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sigma_delta_adc_post;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] in_data;
   logic        in_valid;
   logic        dc_bypass;
   logic        clr_status;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic        sat_flag;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   sigma_delta_adc_post #(
      .IN_W(18), .OUT_W(16), .DC_SHIFT(10), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .dc_bypass(dc_bypass), .clr_status(clr_status), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
      .overflow(overflow), .sat_flag(sat_flag), .drop_cnt(drop_cnt)
   );

   int n_err = 0;
   int n_chk = 0;

   // ---------------- reference model ----------------
   typedef struct { int due; int val; bit sat; } pend_t;
   pend_t  pend[$];
   int     mq[$];
   longint m_acc;
   bit     m_ovf, m_sat;
   int     m_drop;
   int     cyc = 0;

   function automatic longint fdiv(longint a, longint b);
      longint q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   task automatic model_sample(input logic [17:0] d, output int val, output bit sat);
      longint x, y, r;
      x = longint'(d) - 131072;
      if (dc_bypass) begin
         y = x;
      end else begin
         y = x - fdiv(m_acc, 1024);
         m_acc = m_acc + y;
      end
      r = fdiv(y + 2, 4);
      sat = (r > 32767) || (r < -32768);
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      val = int'(r);
   endtask

   task automatic model_edge(input bit iv, input logic [17:0] d, input bit rdy, input bit clr);
      int  e, aval, v;
      bit  arrive, satevt, pop, drop, s;
      cyc++;
      e = cyc;
      arrive = 0; satevt = 0; drop = 0; aval = 0;
      foreach (pend[i]) if (pend[i].due == e + 1 && pend[i].sat) satevt = 1;
      if (pend.size() > 0 && pend[0].due == e) begin
         arrive = 1; aval = pend[0].val; void'(pend.pop_front());
      end
      pop = (mq.size() > 0) && rdy;
      if (arrive && !(mq.size() < DEPTH || pop)) drop = 1;
      if (pop) void'(mq.pop_front());
      if (arrive && !drop) mq.push_back(aval);
      if (clr) begin m_ovf = 0; m_sat = 0; m_drop = 0; end
      if (drop) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
      if (satevt) m_sat = 1;
      if (iv) begin
         model_sample(d, v, s);
         pend.push_back('{due: e + 3, val: v, sat: s});
      end
   endtask

   task automatic model_reset();
      cyc++;
      pend.delete(); mq.delete();
      m_acc = 0; m_ovf = 0; m_sat = 0; m_drop = 0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("out_valid", longint'(out_valid), longint'(mq.size() > 0));
      chk("fifo_level", longint'(fifo_level), longint'(mq.size()));
      if (mq.size() > 0) chk("out_data", longint'($signed(out_data)), longint'(mq[0]));
      chk("overflow", longint'(overflow), longint'(m_ovf));
      chk("sat_flag", longint'(sat_flag), longint'(m_sat));
      chk("drop_cnt", longint'(drop_cnt), longint'(m_drop));
   endtask

   // One clock: drive at negedge, model the edge, compare at next negedge
   task automatic cycle(input bit iv, input logic [17:0] d, input bit rdy, input bit clr);
      in_valid = iv; in_data = d; out_ready = rdy; clr_status = clr;
      @(posedge clk);
      model_edge(iv, d, rdy, clr);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset(input bit iv);
      rst = 1'b0; in_valid = iv; in_data = 18'h21000; out_ready = 1'b0; clr_status = 1'b0;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      compare_all();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 18'h0, rdy, 1'b0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct { logic [17:0] d; int exp; bit sat; } vec_t;
   vec_t vecs[10];

   initial begin
      int  first_seen;
      bit  iv, rdy, clr;
      logic [17:0] d;

      vecs[0] = '{18'h20000,      0, 1'b0};
      vecs[1] = '{18'h20006,      2, 1'b0};
      vecs[2] = '{18'h00000, -32768, 1'b0};
      vecs[3] = '{18'h3FFFF,  32767, 1'b1};
      vecs[4] = '{18'h20001,      0, 1'b0};
      vecs[5] = '{18'h20002,      1, 1'b0};
      vecs[6] = '{18'h1FFFE,      0, 1'b0};
      vecs[7] = '{18'h1FFFA,     -1, 1'b0};
      vecs[8] = '{18'h3FFFD,  32767, 1'b0};
      vecs[9] = '{18'h3FFFE,  32767, 1'b1};

      rst = 1'b0; in_valid = 1'b0; in_data = '0; dc_bypass = 1'b1;
      clr_status = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      do_reset(1'b1);
      chk("reset_valid", longint'(out_valid), 0);
      chk("reset_level", longint'(fifo_level), 0);
      chk("reset_data", longint'(out_data), 0);
      idle(4, 1'b0);
      chk("reset_inval_ignored", longint'(out_valid), 0);

      // Requantizer vectors with bypass: value, latency and sat flag
      foreach (vecs[k]) begin
         cycle(1'b1, vecs[k].d, 1'b0, 1'b1);
         idle(2, 1'b0);
         chk("vec_latency", longint'(out_valid), 0);
         idle(1, 1'b0);
         chk("vec_valid", longint'(out_valid), 1);
         chk("vec_data", longint'($signed(out_data)), longint'(vecs[k].exp));
         chk("vec_sat", longint'(sat_flag), longint'(vecs[k].sat));
         cycle(1'b0, 18'h0, 1'b1, 1'b0);
         if (vecs[k].sat) begin
            cycle(1'b0, 18'h0, 1'b0, 1'b1);
            chk("clr_sat", longint'(sat_flag), 0);
         end
      end

      // DC removal convergence on a constant input
      do_reset(1'b0);
      dc_bypass = 1'b0;
      first_seen = 0;
      for (int i = 0; i < 8192; i++) begin
         cycle(1'b1, 18'h21000, 1'b1, 1'b0);
         if (out_valid && !first_seen) begin
            first_seen = 1;
            chk("dc_first_idx", longint'(i), 3);
            chk("dc_first", longint'($signed(out_data)), 1024);
         end
      end
      idle(3, 1'b0);
      chk("dc_final_small",
          longint'(($signed(out_data) <= 1) && ($signed(out_data) >= -1)), 1);
      idle(6, 1'b1);

      // Overflow: 10 strobes into a stalled FIFO, then in-order drain
      do_reset(1'b0);
      dc_bypass = 1'b1;
      for (int i = 0; i < 10; i++) cycle(1'b1, 18'h20000 + 18'(4 * i), 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("ovf_level", longint'(fifo_level), 8);
      chk("ovf_flag", longint'(overflow), 1);
      chk("ovf_drop", longint'(drop_cnt), 2);
      for (int i = 0; i < 8; i++) begin
         chk("ovf_order", longint'($signed(out_data)), longint'(i));
         cycle(1'b0, 18'h0, 1'b1, 1'b0);
      end
      chk("ovf_empty", longint'(out_valid), 0);
      cycle(1'b0, 18'h0, 1'b1, 1'b1);
      chk("ovf_clr", longint'(drop_cnt), 0);

      // Reset with buffered samples and in_valid asserted during reset
      dc_bypass = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 18'h21000, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("rst_buffered", longint'(fifo_level), 3);
      do_reset(1'b1);
      chk("rst_valid", longint'(out_valid), 0);
      chk("rst_level", longint'(fifo_level), 0);
      cycle(1'b1, 18'h21000, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("rst_acc_zero", longint'($signed(out_data)), 1024);
      idle(2, 1'b1);

      // Randomized traffic, bypass on then off; bypass only changes when drained
      for (int seg = 0; seg < 2; seg++) begin
         dc_bypass = (seg == 0);
         for (int i = 0; i < 1500; i++) begin
            iv  = ($urandom_range(0, 1) == 1);
            rdy = (i < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 7))
               0:       d = 18'h3FFFF;
               1:       d = 18'h00000;
               default: d = 18'($urandom);
            endcase
            cycle(iv, d, rdy, clr);
         end
         idle(14, 1'b1);
         chk("rand_drained", longint'(out_valid), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
